hack_mul_seq: RTL and testbench

HACK_MUL_SEQ -- requirements
Module: hack_mul_seq

---
 rtl/hack_mul_seq.sv | 133 +++++++++++++
 tb/tb_hack_mul_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hack_mul_seq.sv
//------------------------------------------------------------------------------
// Module   : hack_mul_seq (with helper alu_basic)
// Brief    : 16x16 shift-and-add multiplier; every addition goes through a Hack ALU.
//            Optional macro HACK_MUL_EARLY_EXIT_EN ends RUN once the remaining multiplier is zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_basic #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         zx,
    input  logic         nx,
    input  logic         zy,
    input  logic         ny,
    input  logic         f,
    input  logic         no,
    output logic [W-1:0] out
);
    logic [W-1:0] w_x0, w_x1, w_y0, w_y1, w_f;

    always_comb begin
        w_x0 = zx ? '0 : x;
        w_x1 = nx ? ~w_x0 : w_x0;
        w_y0 = zy ? '0 : y;
        w_y1 = ny ? ~w_y0 : w_y0;
        w_f  = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
        out  = no ? ~w_f : w_f;
    end
endmodule

module hack_mul_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] C_ALU_ADD = 6'b000010;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_acc, r_mcand, r_mplier;
    logic [3:0]   r_count;
    logic [W-1:0] w_alu_out;
    logic         w_last;
    logic         w_accept;

    alu_basic #(.W(W)) u_alu (
        .x   (r_acc),
        .y   (r_mcand),
        .zx  (C_ALU_ADD[5]),
        .nx  (C_ALU_ADD[4]),
        .zy  (C_ALU_ADD[3]),
        .ny  (C_ALU_ADD[2]),
        .f   (C_ALU_ADD[1]),
        .no  (C_ALU_ADD[0]),
        .out (w_alu_out)
    );

`ifdef HACK_MUL_EARLY_EXIT_EN
    // Stop as soon as the multiplier shifted this edge leaves no set bits.
    assign w_last = (r_count == 4'd15) || (r_mplier[W-1:1] == '0);
`else
    assign w_last = (r_count == 4'd15);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
            r_count  <= '0;
        end else if (r_state == RUN) begin
            if (r_mplier[0]) r_acc <= w_alu_out;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 4'd1;
        end
    end

    assign product = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_hack_mul_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_hack_mul_seq
// Brief    : Scoreboard bench for hack_mul_seq; directed vectors, queue-based monitor.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hack_mul_seq;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] product;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp;
    int          n_err;
    int          cyc;
    logic [15:0] last_prod;

    hack_mul_seq #(.W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [15:0] bv);
`ifdef HACK_MUL_EARLY_EXIT_EN
        int h;
        h = 0;
        for (int i = 0; i < 16; i++) if (bv[i]) h = i;
        return h + 1;
`else
        return (bv === 16'hxxxx) ? 0 : 16;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("product", int'(product), int'(e.prod));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns #1 after the accepting edge.
    task automatic do_mul(input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] pv, input bit push);
        exp_t e;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_busy", int'(busy), 1);
        chk("accept_clear", int'(product), 0);
        if (push) begin
            e.prod = pv;
            e.cyc  = cyc + lat(bv);
            sb_q.push_back(e);
            last_prod = pv;
        end
    endtask

    // Leaves the caller on the first negedge of IDLE.
    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        else     chk("idle_hold", int'(product), int'(last_prod));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        last_prod = 16'h0000;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_product", int'(product), 0);
        rst_n = 1'b1;

        // Start on the first edge after reset release.
        do_mul(16'h000A, 16'h0003, 16'h001E, 1'b1);
        wait_idle();
        do_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
        wait_idle();
        do_mul(16'h0100, 16'h0100, 16'h0000, 1'b1);
        wait_idle();
        do_mul(16'h1234, 16'h0010, 16'h2340, 1'b1);
        wait_idle();
        do_mul(16'h00FF, 16'h0101, 16'hFFFF, 1'b1);
        wait_idle();
        do_mul(16'hFFFE, 16'h0003, 16'hFFFA, 1'b1);
        wait_idle();
        do_mul(16'h1357, 16'h0001, 16'h1357, 1'b1);
        wait_idle();
        do_mul(16'hBEEF, 16'h0000, 16'h0000, 1'b1);
        wait_idle();
        do_mul(16'h0003, 16'h8000, 16'h8000, 1'b1);
        wait_idle();

        // Restart attempt during RUN must be ignored.
        do_mul(16'h000A, 16'h0003, 16'h001E, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 16'h0005; b = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ignored_restart_idle", int'(busy), 0);
        chk("ignored_restart_hold", int'(product), 16'h001E);

        // Reset in the middle of a multiplication: no done may follow.
        do_mul(16'h00AB, 16'h0011, 16'h0000, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_product", int'(product), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrun_rst_stays_idle", int'(busy), 0);
        last_prod = 16'h0000;
        do_mul(16'h0007, 16'h0006, 16'h002A, 1'b1);
        wait_idle();

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
